// File: rtl/bcd_seg_driver.sv
// Binary (0..1023) to 4-digit BCD converter with multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero one.
module bcd_seg_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] value,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_n;
    logic [9:0]    last_val, last_val_n;
    logic [9:0]    shreg, shreg_n;
    logic [15:0]   bcd, bcd_n, adj;
    logic [15:0]   digits, digits_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [CW-1:0] ref_cnt;
    logic [1:0]    sel;
    logic [3:0]    cur;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;

    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        last_val_n = last_val;
        shreg_n    = shreg;
        bcd_n      = bcd;
        digits_n   = digits;
        bit_cnt_n  = bit_cnt;
        adj = {nib_adj(bcd[15:12]), nib_adj(bcd[11:8]), nib_adj(bcd[7:4]), nib_adj(bcd[3:0])};
        case (state)
            IDLE: begin
                if (value != last_val) begin
                    shreg_n    = value;
                    bcd_n      = '0;
                    last_val_n = value;
                    bit_cnt_n  = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                // Double-dabble: adjust nibbles, then shift {bcd, shreg} left one bit
                {bcd_n, shreg_n} = {adj[14:0], shreg, 1'b0};
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == 4'd9)
                    state_n = DONE;
            end
            DONE: begin
                digits_n = bcd;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case (sel)
            2'd0:    cur = digits[3:0];
            2'd1:    cur = digits[7:4];
            2'd2:    cur = digits[11:8];
            default: cur = digits[15:12];
        endcase
        seg_n = seg_of(cur);
        an_n  = ~(4'b0001 << sel);
`ifdef LEADING_ZERO_BLANK_EN
        if (sel == 2'd3 && digits[15:12] == 4'd0)
            an_n = '1;
        else if (sel == 2'd2 && digits[15:8] == 8'd0)
            an_n = '1;
        else if (sel == 2'd1 && digits[15:4] == 12'd0)
            an_n = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            last_val <= '0;
            shreg    <= '0;
            bcd      <= '0;
            digits   <= '0;
            bit_cnt  <= '0;
            ref_cnt  <= '0;
            sel      <= '0;
            an       <= '1;
            seg      <= '1;
        end else begin
            state    <= state_n;
            last_val <= last_val_n;
            shreg    <= shreg_n;
            bcd      <= bcd_n;
            digits   <= digits_n;
            bit_cnt  <= bit_cnt_n;
            an       <= an_n;
            seg      <= seg_n;
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                sel     <= sel + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + CW'(1);
            end
        end
    end

endmodule
